coeff_reader: RTL
=================

COEFF_READER -- requirements
Module: coeff_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, coefficient word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, coefficient RAM entries, legal range DEPTH >= 2 (power of two not required).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port restart  input  1  single-cycle request to rewind the read address to 0.
REQ-007 SHALL have port ren  output  1  RAM read enable.
REQ-008 SHALL have port rAddr  output  $clog2(DEPTH)  RAM read address.
REQ-009 SHALL have port rdata  input  WIDTH  RAM read data, valid one cycle after ren is sampled.
REQ-010 SHALL have port m_axis_tdata  output  WIDTH  coefficient stream data.
REQ-011 SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-012 SHALL have port m_axis_tready  input  1  stream ready.
REQ-013 SHALL have port m_axis_tlast  output  1  high on the word read from address DEPTH-1.
REQ-014 SHALL have port busy  output  1  high in RUN and DRAIN states.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN; transitions: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when no read is in flight and the output buffer is empty; DRAIN->RUN when en=1.
REQ-016 SHALL assert ren only in RUN, and only when (buffered words + in-flight reads - words popped this cycle) < 2.
REQ-017 SHALL increment rAddr on every cycle with ren=1, wrapping from DEPTH-1 to 0 via explicit compare.
REQ-018 SHALL write rdata, together with a tlast tag (tag = 1 iff its address was DEPTH-1), into a 2-entry output FIFO on the cycle after each ren.
REQ-019 SHALL drive m_axis_tvalid = FIFO not empty and m_axis_tdata/m_axis_tlast from the FIFO head; a word transfers on tvalid & tready.
REQ-020 SHALL hold tdata, tlast and tvalid stable while tvalid=1 and tready=0.
REQ-021 SHALL sustain one word per cycle when tready is held at 1 in RUN.
REQ-022 SHALL raise the first m_axis_tvalid after the 2nd rising edge following the edge at which en is first sampled high in IDLE.
REQ-023 SHALL act on restart only in IDLE (rAddr <= 0 at the next edge); restart in RUN or DRAIN SHALL be ignored.
REQ-024 SHALL retain rAddr across RUN->DRAIN->IDLE so that a later run resumes at the next unread address.
REQ-025 SHALL never drop or duplicate a word under any tready pattern, and never overflow the FIFO.

Reset
REQ-026 SHALL on rst_n=0, asynchronously, set state IDLE, rAddr=0, ren=0, FIFO empty, in-flight flag 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
REQ-027 SHALL discard any in-flight read and any buffered words when reset is asserted mid-run; after deassertion, the stream restarts at address 0 once en=1.

Structure
REQ-028 SHALL place the state enum typedef in the shared package coeff_pkg.
REQ-029 SHALL implement the output buffer as sub-module skid_fifo2 (2 entries, WIDTH+1 bits, push/pop/full/empty/count).

Verification
REQ-030 SHALL test streaming: DEPTH=64, RAM[i]=16'h1000+i, en=1, tready=1 for 130 words -> tdata 1000..103F, 1000..103F, 1000, 1001 back-to-back, tlast only on 103F.
REQ-031 SHALL test backpressure: tready random at 30% duty for 200 words -> exact sequence 1000+(n mod 64), no gaps or repeats, and REQ-020 holds throughout.
REQ-032 SHALL test stop/resume: drop en after word 1009 is accepted -> busy falls after the buffer drains; re-raise en -> stream continues with no loss or repeat of addresses.
REQ-033 SHALL test restart: pulse restart in IDLE after a partial run -> next run starts at 1000; restart pulsed in RUN -> no effect on the sequence.
REQ-034 SHALL test reset mid-run: assert rst_n=0 with 2 words buffered -> tvalid=0 immediately; after release and en=1, the first word is 1000.
REQ-035 SHALL test latency: en rises at edge k with tready=1 -> tvalid=1 after edge k+2 with tdata=1000.

Source files
------------

// File: rtl/coeff_pkg.sv
// rtl/coeff_pkg.sv - shared types for the coefficient reader
// Contents:
//   state_t         reader control states (IDLE, RUN, DRAIN)
//   FIFO_ENTRIES    depth of the output buffer
//   occupancy_ok()  read-issue gate shared by the control logic
package coeff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_ENTRIES = 2;

    // A new read may be issued only if the word it returns is guaranteed
    // a FIFO slot: buffered + in-flight - popped must leave room for it.
    function automatic logic occupancy_ok(input logic [1:0] count,
                                          input logic       inflight,
                                          input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(FIFO_ENTRIES);
    endfunction

endpackage

// File: rtl/coeff_reader_skid_fifo2.sv
// rtl/coeff_reader_skid_fifo2.sv - two-entry output buffer for the coefficient stream
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write strobe and word (ignored when full)
//   pop             read strobe (ignored when empty)
//   rdata           head entry, valid while !empty
//   full, empty     status flags
//   count           number of stored entries (0..2)
module skid_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/coeff_reader.sv
// rtl/coeff_reader.sv - streams coefficient RAM contents out as an AXI-Stream-like word stream
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en                          run request (level)
//   restart                     rewind read address to 0 (honoured in IDLE only)
//   ren, rAddr, rdata           synchronous RAM read port (data one cycle after ren)
//   m_axis_tdata/tvalid/tready/tlast   coefficient stream, tlast on address DEPTH-1
//   busy                        high in RUN and DRAIN
module coeff_reader
    import coeff_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     restart,
    output logic                     ren,
    output logic [$clog2(DEPTH)-1:0] rAddr,
    input  logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t         state;
    state_t         state_next;
    logic           inflight;
    logic           inflight_last;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [1:0]     fifo_count;
    logic [WIDTH:0] fifo_head;

    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_head[WIDTH-1:0];
    assign m_axis_tlast  = fifo_head[WIDTH];
    assign busy          = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        ren        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_next = ST_RUN;
            end
            ST_RUN: begin
                // A full buffer that is not draining this cycle already
                // fails the occupancy test; the extra term keeps the
                // no-overflow guarantee visible at the gate itself.
                ren = occupancy_ok(fifo_count, inflight, pop) && !(fifo_full && !pop);
                if (!en) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en)
                    state_next = ST_RUN;
                else if (!inflight && fifo_empty)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rAddr is left untouched outside reads so a later run resumes at the
    // next unread address; restart only rewinds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rAddr         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ren;
            inflight_last <= ren && (rAddr == LAST_ADDR);
            if (ren) begin
                if (rAddr == LAST_ADDR)
                    rAddr <= '0;
                else
                    rAddr <= rAddr + AW'(1);
            end else if (state == ST_IDLE && restart) begin
                rAddr <= '0;
            end
        end
    end

    // The read issued last cycle returns now; it is pushed with its tlast tag.
    skid_fifo2 #(
        .W(WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .wdata ({inflight_last, rdata}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
